if_stage: RTL and testbench

- Instruction-fetch stage of the 5-stage MIPS pipeline; the producing end of the IF->ID interface.
- Generates fetch requests on an SRAM-like instruction port (pre-IF) and waits for returned data (IF).
- Presents {inst, pc} to ID over fs_to_ds_bus with a valid/allowin handshake.
- Consumes ID's branch bus and WB's exception/eret redirects to steer nextpc.

---
 rtl/if_stage_pkg.sv | 16 +
 rtl/if_stage.sv | 141 ++++++++++++++
 tb/tb_if_stage.sv | 199 +++++++++++++++++++
 3 files changed

// File: rtl/if_stage_pkg.sv
// Shared widths, reset/exception vectors and bus layouts for the IF stage.
package if_stage_pkg;

    localparam int FS_TO_DS_BUS_WD = 64;
    localparam int BR_BUS_WD       = 34;

    localparam logic [31:0] RESET_PC_DEF = 32'hbfc00000;
    localparam logic [31:0] EX_ENTRY_DEF = 32'hbfc00380;

    typedef struct packed {
        logic        stall;
        logic        taken;
        logic [31:0] target;
    } br_bus_t;

endpackage

// File: rtl/if_stage.sv
// MIPS instruction-fetch stage: issues SRAM-like fetch requests, buffers returned
// instructions and redirects (branch, exception, eret) until they can be consumed.
module if_stage
    import if_stage_pkg::*;
#(
    parameter logic [31:0] RESET_PC = RESET_PC_DEF,
    parameter logic [31:0] EX_ENTRY = EX_ENTRY_DEF
) (
    input  logic                       clk,
    input  logic                       resetn,
    input  logic                       ds_allowin,
    input  logic [BR_BUS_WD-1:0]       br_bus,
    output logic                       fs_to_ds_valid,
    output logic [FS_TO_DS_BUS_WD-1:0] fs_to_ds_bus,
    input  logic                       ws_ex,
    input  logic                       eret_flush,
    input  logic [31:0]                cp0_epc,
    output logic                       inst_sram_req,
    output logic                       inst_sram_wr,
    output logic [1:0]                 inst_sram_size,
    output logic [3:0]                 inst_sram_wstrb,
    output logic [31:0]                inst_sram_addr,
    output logic [31:0]                inst_sram_wdata,
    input  logic                       inst_sram_addr_ok,
    input  logic                       inst_sram_data_ok,
    input  logic [31:0]                inst_sram_rdata
);

    br_bus_t     br;
    logic        flush;
    logic [31:0] flush_pc;
    logic        live_br;
    logic        br_hold;
    logic        fs_ready_go;
    logic        fs_allowin;
    logic        accept;
    logic        to_ds_fire;
    logic [31:0] nextpc;

    logic        fs_valid;
    logic [31:0] fs_pc;
    logic        inst_buf_valid;
    logic [31:0] inst_buf;
    logic        br_buf_valid;
    logic [31:0] br_buf_target;
    logic        flush_buf_valid;
    logic [31:0] flush_buf_pc;
    logic        discard;

    assign br       = br_bus;
    assign flush    = ws_ex | eret_flush;
    assign flush_pc = ws_ex ? EX_ENTRY : cp0_epc;

    // A taken branch only redirects once its delay slot is resident in IF.
    assign live_br  = br.taken & ~br.stall & fs_valid;
    assign br_hold  = br.stall & ~br_buf_valid & ~flush_buf_valid;

    always_comb begin
        nextpc = fs_pc + 32'd4;
        if (flush_buf_valid) begin
            nextpc = flush_buf_pc;
        end else if (flush) begin
            nextpc = flush_pc;
        end else if (br_buf_valid) begin
            nextpc = br_buf_target;
        end else if (live_br) begin
            nextpc = br.target;
        end
    end

    assign fs_ready_go    = inst_buf_valid | (inst_sram_data_ok & ~discard);
    assign fs_allowin     = ~fs_valid | (fs_ready_go & ds_allowin);
    assign inst_sram_req  = resetn & fs_allowin & ~flush & ~discard & ~br_hold;
    assign accept         = inst_sram_req & inst_sram_addr_ok;
    assign fs_to_ds_valid = fs_valid & fs_ready_go & ~flush;
    assign to_ds_fire     = fs_to_ds_valid & ds_allowin;

    assign fs_to_ds_bus    = {(inst_buf_valid ? inst_buf : inst_sram_rdata), fs_pc};
    assign inst_sram_addr  = nextpc;
    assign inst_sram_wr    = 1'b0;
    assign inst_sram_size  = 2'd2;
    assign inst_sram_wstrb = 4'd0;
    assign inst_sram_wdata = 32'd0;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            fs_valid        <= 1'b0;
            fs_pc           <= RESET_PC - 32'd4;
            inst_buf_valid  <= 1'b0;
            inst_buf        <= 32'd0;
            br_buf_valid    <= 1'b0;
            br_buf_target   <= 32'd0;
            flush_buf_valid <= 1'b0;
            flush_buf_pc    <= 32'd0;
            discard         <= 1'b0;
        end else if (flush) begin
            fs_valid        <= 1'b0;
            inst_buf_valid  <= 1'b0;
            br_buf_valid    <= 1'b0;
            flush_buf_valid <= 1'b1;
            flush_buf_pc    <= flush_pc;
            // Data arriving in the flush cycle itself is simply dropped.
            if (discard && inst_sram_data_ok) begin
                discard <= 1'b0;
            end else if (fs_valid && !inst_buf_valid && !inst_sram_data_ok) begin
                discard <= 1'b1;
            end
        end else begin
            if (accept) begin
                fs_valid <= 1'b1;
                fs_pc    <= nextpc;
            end else if (to_ds_fire) begin
                fs_valid <= 1'b0;
            end

            if (to_ds_fire) begin
                inst_buf_valid <= 1'b0;
            end else if (inst_sram_data_ok && !discard && fs_valid && !ds_allowin
                         && !inst_buf_valid) begin
                inst_buf       <= inst_sram_rdata;
                inst_buf_valid <= 1'b1;
            end

            if (accept && flush_buf_valid) begin
                flush_buf_valid <= 1'b0;
            end

            if (accept && !flush_buf_valid && br_buf_valid) begin
                br_buf_valid <= 1'b0;
            end else if (live_br && !accept && !br_buf_valid && !flush_buf_valid) begin
                br_buf_valid  <= 1'b1;
                br_buf_target <= br.target;
            end

            if (discard && inst_sram_data_ok) begin
                discard <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_if_stage.sv
// Directed, table-driven bench for if_stage: one vector per clock cycle plus
// a hand-written asynchronous reset sequence.
module tb_if_stage;

    logic        clk = 1'b0;
    logic        resetn;
    logic        ds_allowin;
    logic [33:0] br_bus;
    logic        fs_to_ds_valid;
    logic [63:0] fs_to_ds_bus;
    logic        ws_ex;
    logic        eret_flush;
    logic [31:0] cp0_epc;
    logic        inst_sram_req;
    logic        inst_sram_wr;
    logic [1:0]  inst_sram_size;
    logic [3:0]  inst_sram_wstrb;
    logic [31:0] inst_sram_addr;
    logic [31:0] inst_sram_wdata;
    logic        inst_sram_addr_ok;
    logic        inst_sram_data_ok;
    logic [31:0] inst_sram_rdata;

    int checks = 0;
    int errors = 0;

    if_stage dut (
        .clk              (clk),
        .resetn           (resetn),
        .ds_allowin       (ds_allowin),
        .br_bus           (br_bus),
        .fs_to_ds_valid   (fs_to_ds_valid),
        .fs_to_ds_bus     (fs_to_ds_bus),
        .ws_ex            (ws_ex),
        .eret_flush       (eret_flush),
        .cp0_epc          (cp0_epc),
        .inst_sram_req    (inst_sram_req),
        .inst_sram_wr     (inst_sram_wr),
        .inst_sram_size   (inst_sram_size),
        .inst_sram_wstrb  (inst_sram_wstrb),
        .inst_sram_addr   (inst_sram_addr),
        .inst_sram_wdata  (inst_sram_wdata),
        .inst_sram_addr_ok(inst_sram_addr_ok),
        .inst_sram_data_ok(inst_sram_data_ok),
        .inst_sram_rdata  (inst_sram_rdata)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        allow;
        logic [33:0] br;
        logic        ex;
        logic        eret;
        logic [31:0] epc;
        logic        aok;
        logic        dok;
        logic [31:0] rdata;
        logic        e_req;
        logic [31:0] e_addr;
        logic        e_valid;
        logic [31:0] e_inst;
        logic [31:0] e_pc;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input logic allow, input logic [33:0] br, input logic ex,
                       input logic eret, input logic [31:0] epc, input logic aok,
                       input logic dok, input logic [31:0] rdata, input logic e_req,
                       input logic [31:0] e_addr, input logic e_valid,
                       input logic [31:0] e_inst, input logic [31:0] e_pc);
        vec_t v;
        v.allow = allow; v.br = br; v.ex = ex; v.eret = eret; v.epc = epc;
        v.aok = aok; v.dok = dok; v.rdata = rdata;
        v.e_req = e_req; v.e_addr = e_addr; v.e_valid = e_valid;
        v.e_inst = e_inst; v.e_pc = e_pc;
        vecs.push_back(v);
    endtask

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic drive_idle();
        ds_allowin = 1'b1; br_bus = '0; ws_ex = 1'b0; eret_flush = 1'b0; cp0_epc = '0;
        inst_sram_addr_ok = 1'b0; inst_sram_data_ok = 1'b0; inst_sram_rdata = '0;
    endtask

    initial begin
        //  allow br            ex eret epc           aok dok rdata         req addr          vld inst          pc
        // Sequential fetch straight out of reset.
        add(1, 34'h0,          0, 0, 32'h0,        1, 0, 32'h0,        1, 32'hbfc00000, 0, 32'h0,        32'h0);
        add(1, 34'h0,          0, 0, 32'h0,        1, 1, 32'h11111111, 1, 32'hbfc00004, 1, 32'h11111111, 32'hbfc00000);
        add(1, 34'h0,          0, 0, 32'h0,        1, 1, 32'h22222222, 1, 32'hbfc00008, 1, 32'h22222222, 32'hbfc00004);
        // ID back-pressure: instruction parked in the buffer.
        add(0, 34'h0,          0, 0, 32'h0,        1, 1, 32'h24010001, 0, 32'h0,        1, 32'h24010001, 32'hbfc00008);
        add(0, 34'h0,          0, 0, 32'h0,        1, 0, 32'hdeadbeef, 0, 32'h0,        1, 32'h24010001, 32'hbfc00008);
        add(1, 34'h0,          0, 0, 32'h0,        0, 0, 32'hdeadbeef, 1, 32'hbfc0000c, 1, 32'h24010001, 32'hbfc00008);
        add(1, 34'h0,          0, 0, 32'h0,        1, 0, 32'hdeadbeef, 1, 32'hbfc0000c, 0, 32'h0,        32'h0);
        add(1, 34'h0,          0, 0, 32'h0,        1, 1, 32'h33333333, 1, 32'hbfc00010, 1, 32'h33333333, 32'hbfc0000c);
        // One-cycle taken branch while the delay slot waits on data.
        add(1, 34'h1bfc00100,  0, 0, 32'h0,        1, 0, 32'h0,        0, 32'h0,        0, 32'h0,        32'h0);
        add(1, 34'h0,          0, 0, 32'h0,        0, 1, 32'h44444444, 1, 32'hbfc00100, 1, 32'h44444444, 32'hbfc00010);
        add(1, 34'h0,          0, 0, 32'h0,        1, 0, 32'h0,        1, 32'hbfc00100, 0, 32'h0,        32'h0);
        // Exception with a request in flight; late data is discarded.
        add(1, 34'h0,          1, 0, 32'h0,        1, 0, 32'h0,        0, 32'h0,        0, 32'h0,        32'h0);
        add(1, 34'h0,          0, 0, 32'h0,        1, 0, 32'h0,        0, 32'h0,        0, 32'h0,        32'h0);
        add(1, 34'h0,          0, 0, 32'h0,        1, 1, 32'h55555555, 0, 32'h0,        0, 32'h0,        32'h0);
        add(1, 34'h0,          0, 0, 32'h0,        1, 0, 32'h0,        1, 32'hbfc00380, 0, 32'h0,        32'h0);
        // eret and taken branch together: eret wins.
        add(1, 34'h1bfc00200,  0, 1, 32'hbfc00500, 1, 0, 32'h0,        0, 32'h0,        0, 32'h0,        32'h0);
        add(1, 34'h0,          0, 0, 32'h0,        1, 1, 32'h66666666, 0, 32'h0,        0, 32'h0,        32'h0);
        add(1, 34'h0,          0, 0, 32'h0,        1, 0, 32'h0,        1, 32'hbfc00500, 0, 32'h0,        32'h0);
        add(1, 34'h0,          0, 0, 32'h0,        1, 1, 32'h77777777, 1, 32'hbfc00504, 1, 32'h77777777, 32'hbfc00500);
        // Stalled branch, then resolved taken.
        add(1, 34'h3bfc00300,  0, 0, 32'h0,        1, 0, 32'h0,        0, 32'h0,        0, 32'h0,        32'h0);
        add(1, 34'h1bfc00300,  0, 0, 32'h0,        1, 1, 32'h88888888, 1, 32'hbfc00300, 1, 32'h88888888, 32'hbfc00504);
        add(1, 34'h0,          0, 0, 32'h0,        0, 1, 32'h99999999, 1, 32'hbfc00304, 1, 32'h99999999, 32'hbfc00300);
        // br_stall holds req low even though IF is empty.
        add(1, 34'h200000000,  0, 0, 32'h0,        1, 0, 32'h0,        0, 32'h0,        0, 32'h0,        32'h0);
        add(1, 34'h0,          0, 0, 32'h0,        1, 0, 32'h0,        1, 32'hbfc00304, 0, 32'h0,        32'h0);
        // PC wrap-around past 0xfffffffc.
        add(1, 34'h1fffffffc,  0, 0, 32'h0,        1, 1, 32'haaaaaaaa, 1, 32'hfffffffc, 1, 32'haaaaaaaa, 32'hbfc00304);
        add(1, 34'h0,          0, 0, 32'h0,        1, 1, 32'hbbbbbbbb, 1, 32'h00000000, 1, 32'hbbbbbbbb, 32'hfffffffc);
        // Flush coinciding with data_ok and ds_allowin: nothing transfers, no discard.
        add(1, 34'h0,          1, 0, 32'h0,        1, 1, 32'hcccccccc, 0, 32'h0,        0, 32'h0,        32'h0);
        add(1, 34'h0,          0, 0, 32'h0,        1, 0, 32'h0,        1, 32'hbfc00380, 0, 32'h0,        32'h0);
        // ws_ex has priority over a simultaneous eret.
        add(1, 34'h0,          1, 1, 32'h12345678, 1, 0, 32'h0,        0, 32'h0,        0, 32'h0,        32'h0);
        add(1, 34'h0,          0, 0, 32'h0,        1, 1, 32'hdddddddd, 0, 32'h0,        0, 32'h0,        32'h0);
        add(1, 34'h0,          0, 0, 32'h0,        1, 0, 32'h0,        1, 32'hbfc00380, 0, 32'h0,        32'h0);

        resetn = 1'b0;
        drive_idle();
        #2;
        chk("reset req", {63'd0, inst_sram_req}, 64'd0);
        chk("reset valid", {63'd0, fs_to_ds_valid}, 64'd0);
        chk("const wr/size/wstrb", {57'd0, inst_sram_wr, inst_sram_size, inst_sram_wstrb},
            {57'd0, 1'b0, 2'd2, 4'd0});
        chk("const wdata", {32'd0, inst_sram_wdata}, 64'd0);
        @(negedge clk);
        @(negedge clk);
        resetn = 1'b1;

        for (int i = 0; i < vecs.size(); i++) begin
            @(negedge clk);
            ds_allowin        = vecs[i].allow;
            br_bus            = vecs[i].br;
            ws_ex             = vecs[i].ex;
            eret_flush        = vecs[i].eret;
            cp0_epc           = vecs[i].epc;
            inst_sram_addr_ok = vecs[i].aok;
            inst_sram_data_ok = vecs[i].dok;
            inst_sram_rdata   = vecs[i].rdata;
            #2;
            chk($sformatf("v%0d req", i), {63'd0, inst_sram_req}, {63'd0, vecs[i].e_req});
            if (vecs[i].e_req) begin
                chk($sformatf("v%0d addr", i), {32'd0, inst_sram_addr}, {32'd0, vecs[i].e_addr});
            end
            chk($sformatf("v%0d valid", i), {63'd0, fs_to_ds_valid}, {63'd0, vecs[i].e_valid});
            if (vecs[i].e_valid) begin
                chk($sformatf("v%0d bus", i), fs_to_ds_bus, {vecs[i].e_inst, vecs[i].e_pc});
            end
        end

        // Asynchronous reset asserted mid-cycle with a request in flight.
        @(negedge clk);
        drive_idle();
        inst_sram_addr_ok = 1'b1;
        #1;
        chk("pre-reset req", {63'd0, inst_sram_req}, 64'd0);
        #1;
        resetn = 1'b0;
        #1;
        chk("async reset req", {63'd0, inst_sram_req}, 64'd0);
        chk("async reset valid", {63'd0, fs_to_ds_valid}, 64'd0);
        @(negedge clk);
        resetn = 1'b1;
        #2;
        chk("post-reset req", {63'd0, inst_sram_req}, 64'd1);
        chk("post-reset addr", {32'd0, inst_sram_addr}, {32'd0, 32'hbfc00000});
        @(negedge clk);
        inst_sram_data_ok = 1'b1;
        inst_sram_rdata   = 32'h0badf00d;
        #2;
        chk("post-reset valid", {63'd0, fs_to_ds_valid}, 64'd1);
        chk("post-reset bus", fs_to_ds_bus, {32'h0badf00d, 32'hbfc00000});
        chk("post-reset next addr", {32'd0, inst_sram_addr}, {32'd0, 32'hbfc00004});

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
